// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a two-entry skid buffer (M drives outputs, S absorbs back-pressure).
// Optional perf counters are built when PIPE_STAGE_PERF_EN is defined; otherwise stall_cnt/bubble_cnt are tied to 0.
module pipe_stage_skid #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned EXC_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [EXC_W-1:0]  in_exc,
    input  logic              in_bd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [EXC_W-1:0]  out_exc,
    output logic              out_bd,
    input  logic              flush,
    output logic [1:0]        occ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  m_data_q, m_data_d, s_data_q, s_data_d;
    logic [EXC_W-1:0]   m_exc_q, m_exc_d, s_exc_q, s_exc_d;
    logic               m_bd_q, m_bd_d, s_bd_q, s_bd_d;
    logic               accept, rel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            m_data_q <= '0;
            m_exc_q  <= '0;
            m_bd_q   <= 1'b0;
            s_data_q <= '0;
            s_exc_q  <= '0;
            s_bd_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            m_data_q <= m_data_d;
            m_exc_q  <= m_exc_d;
            m_bd_q   <= m_bd_d;
            s_data_q <= s_data_d;
            s_exc_q  <= s_exc_d;
            s_bd_q   <= s_bd_d;
        end
    end

    // in_ready depends on the state register only, never on out_ready.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid && in_ready;
    assign rel       = out_valid && out_ready;

    always_comb begin
        state_d  = state_q;
        m_data_d = m_data_q;
        m_exc_d  = m_exc_q;
        m_bd_d   = m_bd_q;
        s_data_d = s_data_q;
        s_exc_d  = s_exc_q;
        s_bd_d   = s_bd_q;
        if (flush) begin
            state_d  = EMPTY;
            m_data_d = '0;
            m_exc_d  = '0;
            m_bd_d   = 1'b0;
            s_data_d = '0;
            s_exc_d  = '0;
            s_bd_d   = 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        m_data_d = in_data;
                        m_exc_d  = in_exc;
                        m_bd_d   = in_bd;
                        state_d  = ONE;
                    end
                end
                ONE: begin
                    if (accept && rel) begin
                        m_data_d = in_data;
                        m_exc_d  = in_exc;
                        m_bd_d   = in_bd;
                    end else if (accept) begin
                        s_data_d = in_data;
                        s_exc_d  = in_exc;
                        s_bd_d   = in_bd;
                        state_d  = FULL;
                    end else if (rel) begin
                        state_d  = EMPTY;
                    end
                end
                FULL: begin
                    if (rel) begin
                        m_data_d = s_data_q;
                        m_exc_d  = s_exc_q;
                        m_bd_d   = s_bd_q;
                        s_data_d = '0;
                        s_exc_d  = '0;
                        s_bd_d   = 1'b0;
                        state_d  = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    assign out_data = out_valid ? m_data_q : '0;
    assign out_exc  = out_valid ? m_exc_q  : '0;
    assign out_bd   = out_valid & m_bd_q;
    assign occ      = state_q;

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_q, bubble_q;

    // Saturating; flush deliberately does not touch these.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_q != '1))
                stall_q <= stall_q + 32'd1;
            if (!out_valid && (bubble_q != '1))
                bubble_q <= bubble_q + 32'd1;
        end
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: table of per-cycle vectors, a queue scoreboard of accepted entries,
// and hand sequences for perf counters (PIPE_STAGE_PERF_EN) and asynchronous reset mid-transfer.
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_bd, out_valid, out_ready, out_bd, flush;
    logic [31:0] in_data, out_data, stall_cnt, bubble_cnt;
    logic [4:0]  in_exc, out_exc;
    logic [1:0]  occ;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  exc;
        logic        bd;
    } ent_t;
    ent_t sb[$];

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic [4:0]  e;
        logic        b;
        logic        ordy;
        logic        fl;
        logic [1:0]  x_occ;
        logic [31:0] x_data;
        logic [4:0]  x_exc;
        logic        x_bd;
        logic        x_rdy;
    } vec_t;
    vec_t tbl[16];

    pipe_stage_skid #(.DATA_W(32), .EXC_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_exc(in_exc), .in_bd(in_bd),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_exc(out_exc), .out_bd(out_bd),
        .flush(flush), .occ(occ), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic iv, input logic [31:0] d, input logic [4:0] e, input logic b,
                                input logic ordy, input logic fl, input logic [1:0] xo,
                                input logic [31:0] xd, input logic [4:0] xe, input logic xb, input logic xr);
        vec_t v;
        v.iv = iv; v.d = d; v.e = e; v.b = b; v.ordy = ordy; v.fl = fl;
        v.x_occ = xo; v.x_data = xd; v.x_exc = xe; v.x_bd = xb; v.x_rdy = xr;
        return v;
    endfunction

    // One clock cycle: drive, check pre-edge outputs against the scoreboard, update model, cross the edge.
    task automatic step(input logic iv, input logic [31:0] d, input logic [4:0] e, input logic b,
                        input logic ordy, input logic fl);
        logic acc, rls;
        ent_t ne;
        in_valid = iv; in_data = d; in_exc = e; in_bd = b; out_ready = ordy; flush = fl;
        @(negedge clk);
        chk("sb_occ", {30'd0, occ}, sb.size());
        chk("sb_in_ready", {31'd0, in_ready}, {31'd0, sb.size() < 2});
        chk("sb_out_valid", {31'd0, out_valid}, {31'd0, sb.size() > 0});
        if (sb.size() > 0) begin
            chk("sb_out_data", out_data, sb[0].data);
            chk("sb_out_exc", {27'd0, out_exc}, {27'd0, sb[0].exc});
            chk("sb_out_bd", {31'd0, out_bd}, {31'd0, sb[0].bd});
        end else begin
            chk("sb_bubble", {out_data, out_exc, out_bd} == '0 ? 32'd0 : 32'd1, 32'd0);
        end
        acc = iv && (sb.size() < 2);
        rls = (sb.size() > 0) && ordy;
        if (fl) begin
            sb.delete();
        end else begin
            if (rls) void'(sb.pop_front());
            if (acc) begin
                ne.data = d; ne.exc = e; ne.bd = b;
                sb.push_back(ne);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] s0, b0;

        // Streaming
        for (int i = 0; i < 5; i++)
            tbl[i] = mk(1, 32'h1000 + i, 0, 0, 1, 0, 1, 32'h1000 + i, 0, 0, 1);
        tbl[5]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        // Skid: A held, B absorbed into S, DEAD refused while full
        tbl[6]  = mk(1, 32'hA, 0, 0, 0, 0, 1, 32'hA, 0, 0, 1);
        tbl[7]  = mk(1, 32'hB, 0, 0, 0, 0, 2, 32'hA, 0, 0, 0);
        tbl[8]  = mk(1, 32'hDEAD, 0, 0, 1, 0, 1, 32'hB, 0, 0, 1);
        tbl[9]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        // Flush in FULL with C presented
        tbl[10] = mk(1, 32'hA, 0, 0, 0, 0, 1, 32'hA, 0, 0, 1);
        tbl[11] = mk(1, 32'hB, 0, 0, 0, 0, 2, 32'hA, 0, 0, 0);
        tbl[12] = mk(1, 32'hC, 3, 1, 0, 1, 0, 0, 0, 0, 1);
        tbl[13] = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        // Exception fields
        tbl[14] = mk(1, 32'h5, 5'd12, 1, 0, 0, 1, 32'h5, 5'd12, 1, 1);
        tbl[15] = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);

        rst_n = 1'b0;
        in_valid = 1'b1; in_data = 32'h55; in_exc = 0; in_bd = 0; out_ready = 0; flush = 0;
        #2;
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", {31'd0, in_ready}, 1);
        chk("rst_occ", {30'd0, occ}, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_bubble", bubble_cnt, 0);
        in_valid = 1'b0;
        #6 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].iv, tbl[i].d, tbl[i].e, tbl[i].b, tbl[i].ordy, tbl[i].fl);
            chk($sformatf("v%0d_occ", i), {30'd0, occ}, {30'd0, tbl[i].x_occ});
            chk($sformatf("v%0d_data", i), out_data, tbl[i].x_data);
            chk($sformatf("v%0d_exc", i), {27'd0, out_exc}, {27'd0, tbl[i].x_exc});
            chk($sformatf("v%0d_bd", i), {31'd0, out_bd}, {31'd0, tbl[i].x_bd});
            chk($sformatf("v%0d_rdy", i), {31'd0, in_ready}, {31'd0, tbl[i].x_rdy});
        end

        // Perf counters: 3 stalled cycles, release, 4 empty cycles
        step(1, 32'h7, 0, 0, 0, 0);
        s0 = stall_cnt; b0 = bubble_cnt;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0);
`ifdef PIPE_STAGE_PERF_EN
        chk("perf_stall", stall_cnt - s0, 3);
        chk("perf_bubble", bubble_cnt - b0, 4);
`else
        chk("perf_stall_off", stall_cnt, 0);
        chk("perf_bubble_off", bubble_cnt, 0);
`endif
        step(1, 32'h8, 0, 0, 0, 0);
        s0 = stall_cnt; b0 = bubble_cnt;
        step(0, 0, 0, 0, 1, 1);
        chk("flush_occ", {30'd0, occ}, 0);
`ifdef PIPE_STAGE_PERF_EN
        chk("flush_stall", stall_cnt, s0);
        chk("flush_bubble", bubble_cnt, b0);
`else
        chk("flush_stall_off", stall_cnt, 0);
        chk("flush_bubble_off", bubble_cnt, 0);
`endif

        // Asynchronous reset while FULL and in_valid held
        step(1, 32'hA, 0, 0, 0, 0);
        step(1, 32'hB, 0, 0, 0, 0);
        chk("pre_rst_occ", {30'd0, occ}, 2);
        in_valid = 1'b1; in_data = 32'hC;
        rst_n = 1'b0;
        #2;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 1);
        chk("mid_rst_occ", {30'd0, occ}, 0);
        chk("mid_rst_stall", stall_cnt, 0);
        sb.delete();
        in_valid = 1'b0;
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(0, 0, 0, 0, 1, 0);
        chk("post_rst_occ", {30'd0, occ}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
